// File: rtl/hpdmc_wrdata.sv
// DDR write-data path: sequences DQS preamble/data/postamble around each WRITE
// and registers the 32-bit sys_clk data into the 16-bit ODDR2 halves.
module hpdmc_wrdata #(
  parameter int BEATS = 2  // 2 or 4 only
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        write,
  input  logic [31:0] wdata,
  input  logic [3:0]  wbe,
  output logic        wdata_ack,
  output logic [15:0] dq_d0,
  output logic [15:0] dq_d1,
  output logic [1:0]  dm_d0,
  output logic [1:0]  dm_d1,
  output logic [1:0]  dqs_d0,
  output logic [1:0]  dqs_d1,
  output logic        dq_oe,
  output logic        dqs_oe,
  output logic        busy,
  output logic        write_err
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, POST} state_t;

  localparam logic [1:0] LAST = 2'(BEATS - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        ack_d;
  logic        err_d;
  logic [15:0] dq_d0_q, dq_d1_q;
  logic [1:0]  dm_d0_q, dm_d1_q;
  logic [1:0]  dqs_d0_q, dqs_d1_q;
  logic        dq_oe_q, dqs_oe_q, busy_q, write_err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (write) state_d = PRE;
      end
      PRE: begin
        ack_d   = 1'b1;
        state_d = DATA;
        cnt_d   = 2'd0;
        err_d   = write;
      end
      DATA: begin
        if (cnt_q != LAST) begin
          ack_d = 1'b1;
          cnt_d = cnt_q + 2'd1;
          err_d = write;
        end else if (write) begin
          // seamless continuation into the next burst
          ack_d = 1'b1;
          cnt_d = 2'd0;
        end else begin
          state_d = POST;
          cnt_d   = 2'd0;
        end
      end
      POST: begin
        state_d = write ? PRE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset outranks the data handshake, so no beat is acknowledged while it is high.
  assign wdata_ack = ack_d & ~sys_rst;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      dq_d0_q     <= 16'h0000;
      dq_d1_q     <= 16'h0000;
      dm_d0_q     <= 2'b11;
      dm_d1_q     <= 2'b11;
      dqs_d0_q    <= 2'b00;
      dqs_d1_q    <= 2'b00;
      dq_oe_q     <= 1'b0;
      dqs_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      write_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dq_oe_q     <= (state_d == DATA);
      dqs_oe_q    <= (state_d != IDLE);
      busy_q      <= (state_d != IDLE);
      dqs_d0_q    <= (state_d == DATA) ? 2'b11 : 2'b00;
      dqs_d1_q    <= 2'b00;
      write_err_q <= err_d;
      // Every ack leads into a DATA cycle; otherwise DQ holds and DM masks.
      if (ack_d) begin
        dq_d0_q <= wdata[31:16];
        dq_d1_q <= wdata[15:0];
        dm_d0_q <= ~wbe[3:2];
        dm_d1_q <= ~wbe[1:0];
      end else begin
        dm_d0_q <= 2'b11;
        dm_d1_q <= 2'b11;
      end
    end
  end

  assign dq_d0     = dq_d0_q;
  assign dq_d1     = dq_d1_q;
  assign dm_d0     = dm_d0_q;
  assign dm_d1     = dm_d1_q;
  assign dqs_d0    = dqs_d0_q;
  assign dqs_d1    = dqs_d1_q;
  assign dq_oe     = dq_oe_q;
  assign dqs_oe    = dqs_oe_q;
  assign busy      = busy_q;
  assign write_err = write_err_q;

endmodule

// File: tb/tb_hpdmc_wrdata.sv
// Directed bench for hpdmc_wrdata: BEATS=2 and BEATS=4 instances, with a
// scoreboard of acknowledged data checked against the DQ/DM outputs.
module tb_hpdmc_wrdata;

  logic        clk = 1'b0;
  logic        rst2, rst4;
  logic        write;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic        sel;

  logic        ack2, ack4;
  logic [15:0] dq0_2, dq1_2, dq0_4, dq1_4;
  logic [1:0]  dm0_2, dm1_2, dm0_4, dm1_4;
  logic [1:0]  dqs0_2, dqs1_2, dqs0_4, dqs1_4;
  logic        dqoe_2, dqsoe_2, busy_2, err_2;
  logic        dqoe_4, dqsoe_4, busy_4, err_4;

  always #5 clk = ~clk;

  hpdmc_wrdata #(.BEATS(2)) u2 (
    .sys_clk(clk), .sys_rst(rst2), .write(write), .wdata(wdata), .wbe(wbe),
    .wdata_ack(ack2), .dq_d0(dq0_2), .dq_d1(dq1_2), .dm_d0(dm0_2), .dm_d1(dm1_2),
    .dqs_d0(dqs0_2), .dqs_d1(dqs1_2), .dq_oe(dqoe_2), .dqs_oe(dqsoe_2),
    .busy(busy_2), .write_err(err_2)
  );

  hpdmc_wrdata #(.BEATS(4)) u4 (
    .sys_clk(clk), .sys_rst(rst4), .write(write), .wdata(wdata), .wbe(wbe),
    .wdata_ack(ack4), .dq_d0(dq0_4), .dq_d1(dq1_4), .dm_d0(dm0_4), .dm_d1(dm1_4),
    .dqs_d0(dqs0_4), .dqs_d1(dqs1_4), .dq_oe(dqoe_4), .dqs_oe(dqsoe_4),
    .busy(busy_4), .write_err(err_4)
  );

  logic        o_ack, o_dqoe, o_dqsoe, o_busy, o_err;
  logic [15:0] o_dq0, o_dq1;
  logic [1:0]  o_dm0, o_dm1, o_dqs0, o_dqs1;

  assign o_ack   = sel ? ack4    : ack2;
  assign o_dq0   = sel ? dq0_4   : dq0_2;
  assign o_dq1   = sel ? dq1_4   : dq1_2;
  assign o_dm0   = sel ? dm0_4   : dm0_2;
  assign o_dm1   = sel ? dm1_4   : dm1_2;
  assign o_dqs0  = sel ? dqs0_4  : dqs0_2;
  assign o_dqs1  = sel ? dqs1_4  : dqs1_2;
  assign o_dqoe  = sel ? dqoe_4  : dqoe_2;
  assign o_dqsoe = sel ? dqsoe_4 : dqsoe_2;
  assign o_busy  = sel ? busy_4  : busy_2;
  assign o_err   = sel ? err_4   : err_2;

  int errors = 0;
  int checks = 0;
  logic [35:0] sb[$];   // {dq_d0, dq_d1, dm_d0, dm_d1}
  logic [15:0] last_dq0, last_dq1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One sys_clk cycle: drive inputs, check this cycle's outputs, queue acked data.
  task automatic cyc(input logic rst, input logic w, input logic [31:0] d, input logic [3:0] be,
                     input logic e_ack, input logic e_dqsoe, input logic e_dqoe,
                     input logic e_busy, input logic e_err);
    logic [35:0] exp;
    @(negedge clk);
    if (sel) begin rst4 = rst; rst2 = 1'b0; end
    else     begin rst2 = rst; rst4 = 1'b1; end
    write = w; wdata = d; wbe = be;
    #1;
    chk("wdata_ack", o_ack, e_ack);
    chk("dqs_oe", o_dqsoe, e_dqsoe);
    chk("dq_oe", o_dqoe, e_dqoe);
    chk("busy", o_busy, e_busy);
    chk("write_err", o_err, e_err);
    chk("dqs_d0", o_dqs0, e_dqoe ? 2'b11 : 2'b00);
    chk("dqs_d1", o_dqs1, 2'b00);
    if (e_dqoe) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got DATA beat expected none queued");
      end else begin
        exp = sb.pop_front();
        chk("dq_d0", o_dq0, exp[35:20]);
        chk("dq_d1", o_dq1, exp[19:4]);
        chk("dm_d0", o_dm0, exp[3:2]);
        chk("dm_d1", o_dm1, exp[1:0]);
        last_dq0 = exp[35:20];
        last_dq1 = exp[19:4];
      end
    end else begin
      chk("dm_d0_idle", o_dm0, 2'b11);
      chk("dm_d1_idle", o_dm1, 2'b11);
      chk("dq_d0_hold", o_dq0, last_dq0);
      chk("dq_d1_hold", o_dq1, last_dq1);
    end
    if (e_ack) sb.push_back({d[31:16], d[15:0], ~be[3:2], ~be[1:0]});
  endtask

  initial begin
    sel = 1'b0; rst2 = 1'b1; rst4 = 1'b1;
    write = 1'b0; wdata = '0; wbe = '0;
    last_dq0 = '0; last_dq1 = '0;
    repeat (3) @(posedge clk);

    // reset state
    cyc(0, 0, 32'h0, 4'h0,        0, 0, 0, 0, 0);
    // single burst
    cyc(0, 1, 32'h0, 4'hF,        0, 0, 0, 0, 0);
    cyc(0, 0, 32'hAAAA5555, 4'hF, 1, 1, 0, 1, 0);
    cyc(0, 0, 32'h12345678, 4'hF, 1, 1, 1, 1, 0);
    cyc(0, 0, 32'h0, 4'hF,        0, 1, 1, 1, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 1, 0, 1, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 0, 0, 0, 0);
    // back-to-back, write in last DATA cycle
    cyc(0, 1, 32'h0, 4'hF,        0, 0, 0, 0, 0);
    cyc(0, 0, 32'h11112222, 4'hF, 1, 1, 0, 1, 0);
    cyc(0, 0, 32'h33334444, 4'hF, 1, 1, 1, 1, 0);
    cyc(0, 1, 32'h55556666, 4'hC, 1, 1, 1, 1, 0);
    cyc(0, 0, 32'h77778888, 4'h3, 1, 1, 1, 1, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 1, 1, 1, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 1, 0, 1, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 0, 0, 0, 0);
    // write in POST
    cyc(0, 1, 32'h0, 4'hF,        0, 0, 0, 0, 0);
    cyc(0, 0, 32'h9999AAAA, 4'hF, 1, 1, 0, 1, 0);
    cyc(0, 0, 32'hBBBBCCCC, 4'hF, 1, 1, 1, 1, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 1, 1, 1, 0);
    cyc(0, 1, 32'h0, 4'h0,        0, 1, 0, 1, 0);
    cyc(0, 0, 32'hDDDDEEEE, 4'hF, 1, 1, 0, 1, 0);
    cyc(0, 0, 32'hFFFF0000, 4'hF, 1, 1, 1, 1, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 1, 1, 1, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 1, 0, 1, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 0, 0, 0, 0);
    // illegal write in PRE
    cyc(0, 1, 32'h0, 4'hF,        0, 0, 0, 0, 0);
    cyc(0, 1, 32'hCAFEBABE, 4'hF, 1, 1, 0, 1, 0);
    cyc(0, 0, 32'hDEADBEEF, 4'hF, 1, 1, 1, 1, 1);
    cyc(0, 0, 32'h0, 4'h0,        0, 1, 1, 1, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 1, 0, 1, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 0, 0, 0, 0);
    // partial byte enables, plus illegal write in first DATA cycle
    cyc(0, 1, 32'h0, 4'hF,        0, 0, 0, 0, 0);
    cyc(0, 0, 32'h01234567, 4'h6, 1, 1, 0, 1, 0);
    cyc(0, 1, 32'h89ABCDEF, 4'hF, 1, 1, 1, 1, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 1, 1, 1, 1);
    cyc(0, 0, 32'h0, 4'h0,        0, 1, 0, 1, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 0, 0, 0, 0);
    chk("sb_empty_b2", sb.size(), 0);

    // BEATS=4: reset in second DATA cycle, then a normal burst
    sel = 1'b1;
    last_dq0 = '0; last_dq1 = '0;
    cyc(1, 0, 32'h0, 4'h0,        0, 0, 0, 0, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0, 4'hF,        0, 0, 0, 0, 0);
    cyc(0, 0, 32'hA1A2A3A4, 4'hF, 1, 1, 0, 1, 0);
    cyc(0, 0, 32'hB1B2B3B4, 4'hF, 1, 1, 1, 1, 0);
    cyc(1, 1, 32'hC1C2C3C4, 4'hF, 0, 1, 1, 1, 0);
    last_dq0 = '0; last_dq1 = '0;
    cyc(0, 0, 32'h0, 4'h0,        0, 0, 0, 0, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0, 4'hF,        0, 0, 0, 0, 0);
    cyc(0, 0, 32'h0F0E0D0C, 4'hF, 1, 1, 0, 1, 0);
    cyc(0, 0, 32'h1F1E1D1C, 4'hE, 1, 1, 1, 1, 0);
    cyc(0, 0, 32'h2F2E2D2C, 4'h7, 1, 1, 1, 1, 0);
    cyc(0, 0, 32'h3F3E3D3C, 4'h0, 1, 1, 1, 1, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 1, 1, 1, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 1, 0, 1, 0);
    cyc(0, 0, 32'h0, 4'h0,        0, 0, 0, 0, 0);
    chk("sb_empty_b4", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hpdmc_wrdata.md
HPDMC_WRDATA -- requirements
Module: hpdmc_wrdata

Interface
REQ-001 Parameter BEATS, default 2, sys_clk cycles per write burst (2 = BL4, 4 = BL8 on x16 DDR); legal values 2 and 4 only.
REQ-002 sys_clk  in  1  single clock; every register in the block is clocked on its rising edge.
REQ-003 sys_rst  in  1  reset; synchronous and active-high.
REQ-004 write  in  1  one-cycle pulse from the command scheduler in the cycle a WRITE command is issued.
REQ-005 wdata  in  32  write data for one sys_clk cycle; [31:16] go out on the rising DQS edge, [15:0] on the falling DQS edge.
REQ-006 wbe  in  4  byte enables for wdata, active-high; [3:2] pair with wdata[31:16], [1:0] pair with wdata[15:0].
REQ-007 wdata_ack  out  1  combinational; high in each cycle in which wdata/wbe are sampled.
REQ-008 dq_d0, dq_d1  out  16 each  registered DQ halves feeding the 16-bit ODDR2 pair.
REQ-009 dm_d0, dm_d1  out  2 each  registered DM halves; active-high mask.
REQ-010 dqs_d0, dqs_d1  out  2 each  registered DQS halves, one bit per byte lane.
REQ-011 dq_oe, dqs_oe  out  1 each  registered output enables for the DQ/DM pads and the DQS pads.
REQ-012 busy  out  1  registered; high whenever state is not IDLE.
REQ-013 write_err  out  1  registered one-cycle pulse flagging an illegal write request.

Function
REQ-014 States: IDLE, PRE, DATA, POST; beat counter cnt is 2 bits wide and counts 0..BEATS-1.
REQ-015 IDLE + write -> PRE; with no write the block stays in IDLE.
REQ-016 PRE -> DATA with cnt=0.
REQ-017 DATA with cnt<BEATS-1 -> DATA, and cnt increments by 1.
REQ-018 DATA with cnt=BEATS-1 and write=1 -> DATA with cnt=0 (seamless burst, no postamble or preamble).
REQ-019 DATA with cnt=BEATS-1 and write=0 -> POST.
REQ-020 POST + write -> PRE; POST with no write -> IDLE.
REQ-021 A write in PRE, or in DATA with cnt<BEATS-1, is ignored and pulses write_err the next cycle; state and cnt are unaffected.
REQ-022 wdata_ack = (state==PRE) or (state==DATA and cnt<BEATS-1) or (state==DATA and cnt=BEATS-1 and write).
REQ-023 Data captured in an ack cycle appears on the outputs in the next cycle: dq_d0=wdata[31:16], dq_d1=wdata[15:0], dm_d0=~wbe[3:2], dm_d1=~wbe[1:0].
REQ-024 In every DATA cycle: dq_oe=1, dqs_oe=1, dqs_d0=2'b11, dqs_d1=2'b00.
REQ-025 In PRE and POST: dqs_oe=1, dqs_d0=dqs_d1=2'b00, dq_oe=0.
REQ-026 In IDLE: dqs_oe=0, dq_oe=0, dqs_d0=dqs_d1=2'b00.
REQ-027 When dq_oe=0, dm_d0=dm_d1=2'b11 and dq_d0/dq_d1 hold their last value.
REQ-028 Latency from the write pulse to the first DATA cycle is exactly 2 sys_clk cycles; a burst occupies exactly BEATS DATA cycles.
REQ-029 All outputs except wdata_ack come from registers; no input reaches any of them combinationally.

Reset
REQ-030 In the cycle after sys_rst is sampled high: state=IDLE, cnt=0, dq_d0=dq_d1=0, dm_d0=dm_d1=2'b11, dqs_d0=dqs_d1=0, dq_oe=0, dqs_oe=0, busy=0, write_err=0.
REQ-031 sys_rst has priority over write; a reset mid-burst abandons the burst without a postamble and without producing any ack.

Verification
REQ-032 Single write (BEATS=2), wdata 0xAAAA5555 then 0x12345678, wbe 4'hF: write@T -> PRE@T+1, ack@T+1 and T+2, DATA@T+2..T+3 with dq_d0/d1 = AAAA/5555 then 1234/5678, dm=00, POST@T+4, IDLE@T+5.
REQ-033 Back-to-back: second write in the last DATA cycle -> no POST/PRE, 4 continuous DATA cycles, dqs_oe never drops.
REQ-034 Write in POST -> PRE next cycle, so dqs_oe stays high throughout and dq_oe=0 for exactly 2 cycles between bursts.
REQ-035 Write while in PRE -> write_err=1 for one cycle, burst length unchanged, no extra ack.
REQ-036 wbe=4'b0110 -> dm_d0=2'b10, dm_d1=2'b01 in that DATA cycle.
REQ-037 BEATS=4, with sys_rst asserted in the second DATA cycle -> all outputs at their reset values in the next cycle, IDLE held, and a later write runs a normal burst.
